// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one-deep request/valid fetch from instruction memory,
// a single-entry skid buffer toward decode, and jump redirect with stale-response dropping.
module instr_fetch_unit #(
   parameter int ADDR_W   = 16,
   parameter int INSTR_W  = 32,
   parameter int RESET_PC = 0,
   parameter int PC_INC   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Enable,
   input  logic               MuxDireccionPC,
   input  logic [ADDR_W-1:0]  JumpTarget,
   input  logic               DecodeStall,
   output logic               IMemReq,
   output logic [ADDR_W-1:0]  IMemAddr,
   input  logic [INSTR_W-1:0] IMemRdata,
   input  logic               IMemRvalid,
   output logic [INSTR_W-1:0] InstrOut,
   output logic [4:0]         OpcodeOut,
   output logic [ADDR_W-1:0]  PCOut,
   output logic               InstrValid
);
   localparam logic [4:0] NOP = 5'b10111;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetchStateT;

   fetchStateT         state, stateNext;
   logic [ADDR_W-1:0]  pc, pcNext, pcOutReg;
   logic [INSTR_W-1:0] instrReg, skidData, loadData;
   logic               instrValid, validNext, load, skidWr;
   logic [1:0]         pend, pendNext, drop, dropNext;
   logic               stale, live;

   // drop counts responses still in flight that belong to a flushed fetch stream
   assign stale = IMemRvalid && (drop != 2'd0);
   assign live  = IMemRvalid && (drop == 2'd0);

   assign IMemReq    = (state == REQ);
   assign IMemAddr   = pc;
   assign InstrOut   = instrReg;
   assign PCOut      = pcOutReg;
   assign InstrValid = instrValid;
   assign OpcodeOut  = instrValid ? instrReg[INSTR_W-1 -: 5] : NOP;

   always_comb begin
      stateNext = state;
      pcNext    = pc;
      load      = 1'b0;
      loadData  = IMemRdata;
      skidWr    = 1'b0;
      validNext = instrValid & DecodeStall;
      pendNext  = pend + {1'b0, IMemReq} - {1'b0, IMemRvalid && (pend != 2'd0)};
      dropNext  = drop - {1'b0, stale};
      unique case (state)
         IDLE: if (Enable) stateNext = REQ;
         REQ:  stateNext = WAIT;
         // a stale response is discarded while the live request stays outstanding
         WAIT: if (live) begin
            if (!instrValid || !DecodeStall) begin
               load      = 1'b1;
               stateNext = Enable ? REQ : IDLE;
            end else begin
               skidWr    = 1'b1;
               stateNext = HOLD;
            end
         end
         HOLD: if (!DecodeStall) begin
            load      = 1'b1;
            loadData  = skidData;
            stateNext = Enable ? REQ : IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (load) begin
         validNext = 1'b1;
         pcNext    = pc + ADDR_W'(PC_INC);
      end
      // redirect wins over stall and Enable; everything in flight becomes stale
      if (MuxDireccionPC) begin
         load      = 1'b0;
         skidWr    = 1'b0;
         validNext = 1'b0;
         pcNext    = JumpTarget;
         dropNext  = pendNext;
         if (state != IDLE) stateNext = REQ;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= ADDR_W'(RESET_PC);
         pend       <= 2'd0;
         drop       <= 2'd0;
         instrReg   <= '0;
         pcOutReg   <= '0;
         instrValid <= 1'b0;
         skidData   <= '0;
      end else begin
         state      <= stateNext;
         pc         <= pcNext;
         pend       <= pendNext;
         drop       <= dropNext;
         instrValid <= validNext;
         if (load) begin
            instrReg <= loadData;
            pcOutReg <= pc;
         end
         if (skidWr) skidData <= IMemRdata;
         else if (MuxDireccionPC) skidData <= '0;
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model with programmable latency,
// a consumption monitor, and one task per scenario with hand-computed expectations.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        reset, Enable, MuxDireccionPC, DecodeStall, IMemRvalid;
   logic [15:0] JumpTarget;
   logic [31:0] IMemRdata;
   logic        IMemReq, InstrValid;
   logic [15:0] IMemAddr, PCOut;
   logic [31:0] InstrOut;
   logic [4:0]  OpcodeOut;

   typedef struct {logic [15:0] pc; logic [31:0] instr; logic [4:0] op; int cyc;} obsT;
   typedef struct {logic [15:0] addr; int due;} pendT;

   obsT         got[$];
   pendT        memQ[$];
   logic [15:0] reqs[$];
   int          cyc = 0;
   int          memLat = 1;
   int          nTests = 0;
   int          nFail = 0;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .Enable(Enable), .MuxDireccionPC(MuxDireccionPC),
      .JumpTarget(JumpTarget), .DecodeStall(DecodeStall), .IMemReq(IMemReq),
      .IMemAddr(IMemAddr), .IMemRdata(IMemRdata), .IMemRvalid(IMemRvalid),
      .InstrOut(InstrOut), .OpcodeOut(OpcodeOut), .PCOut(PCOut), .InstrValid(InstrValid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memWord(input logic [15:0] a);
      case (a)
         16'h0000: memWord = 32'h0000_0000;
         16'h0001: memWord = 32'h0800_0000;
         16'h0002: memWord = 32'hB800_0000;
         default:  memWord = {a[4:0], 11'h000, a};
      endcase
   endfunction

   // memory responder and decode-side monitor, both on the falling edge
   initial begin
      IMemRvalid = 1'b0;
      IMemRdata  = '0;
      forever begin
         @(negedge clk);
         if (IMemReq) reqs.push_back(IMemAddr);
         if (InstrValid && !DecodeStall) got.push_back('{PCOut, InstrOut, OpcodeOut, cyc});
         IMemRvalid = 1'b0;
         if (memQ.size() > 0 && memQ[0].due == cyc) begin
            IMemRdata  = memWord(memQ[0].addr);
            IMemRvalid = 1'b1;
            memQ.delete(0);
         end
         if (IMemReq) memQ.push_back('{IMemAddr, cyc + memLat});
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got %0d cycles, required < 10000", cyc);
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearObs();
      got.delete();
      reqs.delete();
   endtask

   task automatic test_reset();
      reset = 1'b0; Enable = 1'b0; MuxDireccionPC = 1'b0; DecodeStall = 1'b0; JumpTarget = '0;
      step(2);
      nTests++; if (IMemReq !== 1'b0) begin nFail++; $display("FAIL reset_req got %b required 0", IMemReq); end
      nTests++; if (IMemAddr !== 16'h0000) begin nFail++; $display("FAIL reset_addr got %h required 0000", IMemAddr); end
      nTests++; if (InstrValid !== 1'b0) begin nFail++; $display("FAIL reset_valid got %b required 0", InstrValid); end
      nTests++; if (OpcodeOut !== 5'b10111) begin nFail++; $display("FAIL reset_opcode got %b required 10111", OpcodeOut); end
      nTests++; if (InstrOut !== 32'h0 || PCOut !== 16'h0) begin nFail++; $display("FAIL reset_out got %h/%h required 0/0", InstrOut, PCOut); end
      reset = 1'b1;
      step(1);
   endtask

   task automatic test_fetch();
      clearObs();
      memLat = 1;
      Enable = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step(1);
         nTests++; if (InstrValid !== (k == 3)) begin nFail++; $display("FAIL fetch_latency cycle %0d got %b required %b", k, InstrValid, (k == 3)); end
         if (k == 1) begin
            nTests++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0000) begin nFail++; $display("FAIL fetch_first_req got %b/%h required 1/0000", IMemReq, IMemAddr); end
         end
      end
      step(2);
      Enable = 1'b0;
      step(4);
      nTests++; if (got.size() !== 3) begin nFail++; $display("FAIL fetch_count got %0d required 3", got.size()); end
      if (got.size() == 3) begin
         nTests++; if (got[0].op !== 5'b00000 || got[1].op !== 5'b00001 || got[2].op !== 5'b10111) begin nFail++; $display("FAIL fetch_opcodes got %b %b %b required 00000 00001 10111", got[0].op, got[1].op, got[2].op); end
         nTests++; if (got[0].pc !== 16'd0 || got[1].pc !== 16'd1 || got[2].pc !== 16'd2) begin nFail++; $display("FAIL fetch_pcs got %h %h %h required 0 1 2", got[0].pc, got[1].pc, got[2].pc); end
         nTests++; if (got[1].instr !== 32'h0800_0000 || got[2].instr !== 32'hB800_0000) begin nFail++; $display("FAIL fetch_data got %h %h required 08000000 b8000000", got[1].instr, got[2].instr); end
         nTests++; if (got[1].cyc - got[0].cyc !== 2) begin nFail++; $display("FAIL fetch_throughput got %0d required 2", got[1].cyc - got[0].cyc); end
      end
      nTests++; if (reqs.size() !== 3) begin nFail++; $display("FAIL fetch_reqs got %0d required 3", reqs.size()); end
      nTests++; if (InstrValid !== 1'b0 || OpcodeOut !== 5'b10111) begin nFail++; $display("FAIL fetch_idle_nop got %b/%b required 0/10111", InstrValid, OpcodeOut); end
   endtask

   task automatic test_stall_skid();
      clearObs();
      Enable = 1'b1; DecodeStall = 1'b0;
      step(3);
      DecodeStall = 1'b1; Enable = 1'b0;
      step(2);
      for (int k = 0; k < 3; k++) begin
         nTests++; if (InstrValid !== 1'b1 || PCOut !== 16'h0003 || InstrOut !== 32'h1800_0003) begin nFail++; $display("FAIL stall_hold step %0d got %b/%h/%h required 1/0003/18000003", k, InstrValid, PCOut, InstrOut); end
         if (k < 2) step(1);
      end
      DecodeStall = 1'b0;
      step(3);
      nTests++; if (got.size() !== 2) begin nFail++; $display("FAIL skid_count got %0d required 2", got.size()); end
      if (got.size() == 2) begin
         nTests++; if (got[0].pc !== 16'h3 || got[0].instr !== 32'h1800_0003) begin nFail++; $display("FAIL skid_first got %h/%h required 0003/18000003", got[0].pc, got[0].instr); end
         nTests++; if (got[1].pc !== 16'h4 || got[1].instr !== 32'h2000_0004) begin nFail++; $display("FAIL skid_second got %h/%h required 0004/20000004", got[1].pc, got[1].instr); end
         nTests++; if (got[1].cyc - got[0].cyc !== 1) begin nFail++; $display("FAIL skid_consecutive got %0d required 1", got[1].cyc - got[0].cyc); end
      end
   endtask

   task automatic test_redirect_wait();
      clearObs();
      memLat = 3;
      Enable = 1'b1;
      step(2);
      MuxDireccionPC = 1'b1; JumpTarget = 16'h0040;
      step(1);
      MuxDireccionPC = 1'b0; Enable = 1'b0;
      nTests++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0040) begin nFail++; $display("FAIL redir_req got %b/%h required 1/0040", IMemReq, IMemAddr); end
      nTests++; if (InstrValid !== 1'b0 || OpcodeOut !== 5'b10111) begin nFail++; $display("FAIL redir_flush got %b/%b required 0/10111", InstrValid, OpcodeOut); end
      for (int k = 0; k < 3; k++) begin
         step(1);
         nTests++; if (InstrValid !== 1'b0) begin nFail++; $display("FAIL redir_no_stale step %0d got %b required 0", k, InstrValid); end
      end
      step(1);
      nTests++; if (InstrValid !== 1'b1 || PCOut !== 16'h0040 || InstrOut !== 32'h0000_0040) begin nFail++; $display("FAIL redir_target got %b/%h/%h required 1/0040/00000040", InstrValid, PCOut, InstrOut); end
      step(3);
      nTests++; if (got.size() !== 1 || reqs.size() !== 2) begin nFail++; $display("FAIL redir_counts got %0d/%0d required 1/2", got.size(), reqs.size()); end
      memLat = 1;
   endtask

   task automatic test_redirect_rvalid();
      clearObs();
      Enable = 1'b1; DecodeStall = 1'b0;
      step(3);
      DecodeStall = 1'b1; Enable = 1'b0;
      step(1);
      MuxDireccionPC = 1'b1; JumpTarget = 16'h0080;
      step(1);
      MuxDireccionPC = 1'b0; DecodeStall = 1'b0;
      nTests++; if (InstrValid !== 1'b0 || OpcodeOut !== 5'b10111) begin nFail++; $display("FAIL redir_rv_flush got %b/%b required 0/10111", InstrValid, OpcodeOut); end
      nTests++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0080) begin nFail++; $display("FAIL redir_rv_req got %b/%h required 1/0080", IMemReq, IMemAddr); end
      step(4);
      nTests++; if (got.size() !== 1) begin nFail++; $display("FAIL redir_rv_count got %0d required 1", got.size()); end
      if (got.size() == 1) begin
         nTests++; if (got[0].pc !== 16'h0080 || got[0].instr !== 32'h0000_0080) begin nFail++; $display("FAIL redir_rv_data got %h/%h required 0080/00000080", got[0].pc, got[0].instr); end
      end
   endtask

   task automatic test_pc_wrap();
      clearObs();
      MuxDireccionPC = 1'b1; JumpTarget = 16'hFFFF;
      step(1);
      MuxDireccionPC = 1'b0;
      nTests++; if (IMemReq !== 1'b0 || IMemAddr !== 16'hFFFF) begin nFail++; $display("FAIL idle_redirect got %b/%h required 0/ffff", IMemReq, IMemAddr); end
      Enable = 1'b1;
      step(3);
      Enable = 1'b0;
      nTests++; if (InstrValid !== 1'b1 || PCOut !== 16'hFFFF || OpcodeOut !== 5'b11111) begin nFail++; $display("FAIL wrap_last got %b/%h/%b required 1/ffff/11111", InstrValid, PCOut, OpcodeOut); end
      nTests++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0000) begin nFail++; $display("FAIL wrap_next_addr got %b/%h required 1/0000", IMemReq, IMemAddr); end
      step(3);
      nTests++; if (got.size() !== 2) begin nFail++; $display("FAIL wrap_count got %0d required 2", got.size()); end
      if (got.size() == 2) begin
         nTests++; if (got[1].pc !== 16'h0000 || got[1].instr !== 32'h0) begin nFail++; $display("FAIL wrap_data got %h/%h required 0000/00000000", got[1].pc, got[1].instr); end
      end
   endtask

   task automatic test_reset_mid_wait();
      clearObs();
      memLat = 3;
      Enable = 1'b1;
      step(2);
      reset = 1'b0; Enable = 1'b0;
      step(1);
      reset = 1'b1;
      nTests++; if (IMemReq !== 1'b0 || IMemAddr !== 16'h0000 || InstrValid !== 1'b0) begin nFail++; $display("FAIL rst_wait_state got %b/%h/%b required 0/0000/0", IMemReq, IMemAddr, InstrValid); end
      step(3);
      nTests++; if (InstrValid !== 1'b0 || OpcodeOut !== 5'b10111 || IMemReq !== 1'b0) begin nFail++; $display("FAIL rst_late_resp got %b/%b/%b required 0/10111/0", InstrValid, OpcodeOut, IMemReq); end
      nTests++; if (got.size() !== 0 || IMemAddr !== 16'h0000 || PCOut !== 16'h0) begin nFail++; $display("FAIL rst_ignored got %0d/%h/%h required 0/0000/0000", got.size(), IMemAddr, PCOut); end
      Enable = 1'b1;
      step(1);
      Enable = 1'b0;
      nTests++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0000) begin nFail++; $display("FAIL rst_restart got %b/%h required 1/0000", IMemReq, IMemAddr); end
      step(5);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall_skid();
      test_redirect_wait();
      test_redirect_rvalid();
      test_pc_wrap();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
